// File: rtl/m68k_bus_initiator_if.sv
// Request side and 68000-style bus side of the bus-master sequencer.
// master = the initiator, slave = requester plus board responder.
interface m68k_bus_initiator_if;
  logic        i_REQ;
  logic [22:0] i_ADDR;
  logic        i_WE;
  logic [1:0]  i_BE;
  logic [15:0] i_WDATA;
  logic        o_BUSY;
  logic        o_ACK;
  logic        o_ERR;
  logic [15:0] o_RDATA;
  logic [22:0] o_A;
  logic        o_AS_n;
  logic        o_UDS_n;
  logic        o_LDS_n;
  logic        o_RW;
  logic [15:0] o_D;
  logic        o_D_OE;
  logic [15:0] i_D;
  logic        i_DTACK_n;
  logic        i_BERR_n;

  modport master (
    input  i_REQ, i_ADDR, i_WE, i_BE, i_WDATA,
    input  i_D, i_DTACK_n, i_BERR_n,
    output o_BUSY, o_ACK, o_ERR, o_RDATA,
    output o_A, o_AS_n, o_UDS_n, o_LDS_n,
    output o_RW, o_D, o_D_OE
  );

  modport slave (
    output i_REQ, i_ADDR, i_WE, i_BE, i_WDATA,
    output i_D, i_DTACK_n, i_BERR_n,
    input  o_BUSY, o_ACK, o_ERR, o_RDATA,
    input  o_A, o_AS_n, o_UDS_n, o_LDS_n,
    input  o_RW, o_D, o_D_OE
  );
endinterface

// File: rtl/m68k_bus_initiator.sv
// Bus-master sequencer: request/ack in, asynchronous 68000 bus cycles out.
// DTACK/BERR are synchronised; a watchdog aborts cycles nobody answers.
module m68k_bus_initiator #(
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input logic i_CLK,
  input logic i_RST,
  m68k_bus_initiator_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_STROBE,
    S_WAIT,
    S_LATCH,
    S_END,
    S_RECOVER,
    S_ERRDONE
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t state, nxt;

  logic [SYNC_STAGES-1:0] dtack_sr, berr_sr;
  logic dtack_s, berr_s;

  logic [7:0]  cnt, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  be_q, be_d;
  logic [22:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [15:0] rdata_q, rdata_d;
  logic as_q, as_d;
  logic uds_q, uds_d;
  logic lds_q, lds_d;
  logic rw_q, rw_d;
  logic oe_q, oe_d;
  logic busy_q, busy_d;
  logic ack_q, ack_d;
  logic err_q, err_d;
  logic fin, fin_err;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      dtack_sr <= '1;
      berr_sr  <= '1;
    end else begin
      dtack_sr <= {dtack_sr[SYNC_STAGES-2:0], bus.i_DTACK_n};
      berr_sr  <= {berr_sr[SYNC_STAGES-2:0], bus.i_BERR_n};
    end
  end

  assign dtack_s = dtack_sr[SYNC_STAGES-1];
  assign berr_s  = berr_sr[SYNC_STAGES-1];

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      rdata_q <= '0;
      as_q    <= 1'b1;
      uds_q   <= 1'b1;
      lds_q   <= 1'b1;
      rw_q    <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      a_q     <= a_d;
      d_q     <= d_d;
      rdata_q <= rdata_d;
      as_q    <= as_d;
      uds_q   <= uds_d;
      lds_q   <= lds_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    nxt     = state;
    cnt_d   = cnt;
    we_d    = we_q;
    be_d    = be_q;
    a_d     = a_q;
    d_d     = d_q;
    rdata_d = rdata_q;
    as_d    = as_q;
    uds_d   = uds_q;
    lds_d   = lds_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    err_d   = err_q;
    fin     = 1'b0;
    fin_err = 1'b0;

    unique case (state)
      S_IDLE: begin
        // busy_q is still high for one cycle after an ERRDONE ack
        busy_d = 1'b0;
        if (bus.i_REQ && !busy_q) begin
          busy_d = 1'b1;
          we_d   = bus.i_WE;
          be_d   = bus.i_BE;
          if (bus.i_BE == 2'b00) begin
            nxt = S_ERRDONE;
          end else begin
            nxt  = S_ADDR;
            a_d  = bus.i_ADDR;
            rw_d = !bus.i_WE;
            if (bus.i_WE) begin
              d_d  = bus.i_WDATA;
              oe_d = 1'b1;
            end
          end
        end
      end
      S_ADDR: begin
        nxt  = S_STROBE;
        as_d = 1'b0;
        if (!we_q) begin
          uds_d = !be_q[1];
          lds_d = !be_q[0];
        end
      end
      S_STROBE: begin
        nxt   = S_WAIT;
        cnt_d = '0;
        if (we_q) begin
          uds_d = !be_q[1];
          lds_d = !be_q[0];
        end
      end
      S_WAIT: begin
        cnt_d = cnt + 8'd1;
        if (!berr_s) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (!dtack_s) begin
          nxt = S_LATCH;
        end else if (cnt == TO_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      S_LATCH: begin
        if (!we_q) rdata_d = bus.i_D;
        fin = 1'b1;
      end
      S_END: begin
        nxt = S_RECOVER;
      end
      S_RECOVER: begin
        if (dtack_s && berr_s) begin
          nxt    = S_IDLE;
          busy_d = 1'b0;
        end
      end
      S_ERRDONE: begin
        nxt   = S_IDLE;
        ack_d = 1'b1;
        err_d = 1'b1;
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase

    if (fin) begin
      nxt   = S_END;
      as_d  = 1'b1;
      uds_d = 1'b1;
      lds_d = 1'b1;
      oe_d  = 1'b0;
      rw_d  = 1'b1;
      ack_d = 1'b1;
      err_d = fin_err;
    end
  end

  assign bus.o_BUSY  = busy_q;
  assign bus.o_ACK   = ack_q;
  assign bus.o_ERR   = err_q;
  assign bus.o_RDATA = rdata_q;
  assign bus.o_A     = a_q;
  assign bus.o_AS_n  = as_q;
  assign bus.o_UDS_n = uds_q;
  assign bus.o_LDS_n = lds_q;
  assign bus.o_RW    = rw_q;
  assign bus.o_D     = d_q;
  assign bus.o_D_OE  = oe_q;

endmodule
